// File: rtl/lcm_from_hcf.sv
// lcm_from_hcf: least common multiple from two operands and their HCF.
//   The result is computed as lcm = (in1 / hcf) * in2, using an N-cycle
//   restoring divider followed by an N-cycle shift-add multiplier.
//   err is raised when hcf is zero or does not divide in1 exactly.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only while idle
//   in1    first operand (N bits), latched on an accepted start
//   in2    second operand (N bits), latched on an accepted start
//   hcf    upstream HCF of in1/in2 (N bits), latched on an accepted start
//   busy   high while dividing or multiplying
//   done   one-cycle pulse when lcm/err update
//   lcm    2N-bit result, held until the next done
//   err    error flag, held until the next done
module lcm_from_hcf #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  input  logic [N-1:0]   hcf,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] lcm,
  output logic           err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = 2 * N;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t        state;
  logic [N-1:0]  quo;      // dividend shifts out of the top, quotient shifts in at the bottom
  logic [N:0]    rem;
  logic [N-1:0]  hcf_q;
  logic [CW-1:0] cnt;
  logic [LW-1:0] acc;      // product accumulator; stays 0 on every error/short path
  logic [LW-1:0] mcand;    // latched in2, shifted left once per multiplier bit
  logic          res_err;

  logic [N:0]    rem_shift;
  logic          div_ge;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;
  logic [LW-1:0] acc_next;

  // One restoring-division step and one shift-add step.
  // rem < hcf always holds, so its top bit is zero before each shift.
  always_comb begin
    rem_shift = (N+1)'({rem, quo[N-1]});
    div_ge    = (rem_shift >= {1'b0, hcf_q});
    rem_next  = div_ge ? (rem_shift - {1'b0, hcf_q}) : rem_shift;
    quo_next  = N'({quo, div_ge});
    acc_next  = quo[0] ? (acc + mcand) : acc;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      quo     <= '0;
      rem     <= '0;
      hcf_q   <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      res_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lcm     <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo   <= in1;
            hcf_q <= hcf;
            mcand <= LW'(in2);
            rem   <= '0;
            acc   <= '0;
            cnt   <= CW'(N - 1);
            if (in1 == '0 || in2 == '0) begin
              res_err <= 1'b0;
              state   <= DONE;
            end else if (hcf == '0) begin
              res_err <= 1'b1;
              state   <= DONE;
            end else begin
              res_err <= 1'b0;
              busy    <= 1'b1;
              state   <= DIV;
            end
          end
        end

        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            cnt <= CW'(N - 1);
            if (rem_next != '0) begin
              res_err <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end

        // Multiplier bits are consumed LSB first from the quotient register.
        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          quo   <= quo >> 1;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          lcm   <= acc;
          err   <= res_err;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_from_hcf.sv
// tb_lcm_from_hcf: scoreboard bench for lcm_from_hcf (N = 8).
//   Expected results are derived arithmetically when a request is issued and
//   compared when done pulses, along with done timing and busy length.
module tb_lcm_from_hcf;

  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic [N-1:0]   hcf;
  logic           busy;
  logic           done;
  logic [2*N-1:0] lcm;
  logic           err;

  lcm_from_hcf #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .hcf   (hcf),
    .busy  (busy),
    .done  (done),
    .lcm   (lcm),
    .err   (err)
  );

  typedef struct {
    longint lcm;
    bit     err;
    int     due;
    int     bcyc;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  longint last_lcm = 0;
  bit     last_err = 0;
  int     busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: lcm value, err, latency from accept edge, busy cycles.
  task automatic model(input int a, input int b, input int h,
                       output longint l, output bit e, output int lat, output int bc);
    if (a == 0 || b == 0) begin
      l = 0; e = 0; lat = 1; bc = 0;
    end else if (h == 0) begin
      l = 0; e = 1; lat = 1; bc = 0;
    end else if ((a % h) != 0) begin
      l = 0; e = 1; lat = N + 1; bc = N;
    end else begin
      l = longint'(a / h) * longint'(b); e = 0; lat = 2 * N + 1; bc = 2 * N;
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_lcm = 0;
      last_err = 0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("lcm", longint'(lcm), e.lcm);
          chk("err", longint'(err), longint'(e.err));
          chk("done_cycle", longint'(cyc), longint'(e.due));
          chk("busy_cycles", longint'(busy_cnt), longint'(e.bcyc));
          chk("busy_at_done", longint'(busy), 0);
        end
        last_lcm = longint'(lcm);
        last_err = err;
        busy_cnt = 0;
      end else begin
        chk("lcm_hold", longint'(lcm), last_lcm);
        chk("err_hold", longint'(err), longint'(last_err));
      end
    end
  end

  // Drive a one-cycle start; accept edge is the next rising edge.
  task automatic launch(input int a, input int b, input int h, input bit push);
    exp_t   e;
    longint l;
    bit     er;
    int     lat;
    int     bc;
    model(a, b, h, l, er, lat, bc);
    in1   = N'(a);
    in2   = N'(b);
    hcf   = N'(h);
    start = 1'b1;
    if (push) begin
      e.lcm = l; e.err = er; e.due = cyc + 1 + lat; e.bcyc = bc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, input int h);
    launch(a, b, h, 1'b1);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    hcf   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_lcm",  longint'(lcm), 0);
    chk("rst_err",  longint'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal, back-to-back, error and short paths.
    run(27, 45, 9);
    run(56, 84, 28);
    run(108, 24, 12);
    run(255, 254, 1);
    run(100, 70, 3);
    run(49, 77, 0);
    run(0, 45, 9);
    run(17, 0, 1);
    repeat (2) @(posedge clk); #1;

    // Start pulsed mid-computation is ignored.
    launch(27, 45, 9, 1'b1);
    repeat (4) @(posedge clk); #1;
    in1 = 8'd17; in2 = 8'd103; hcf = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Reset mid-run aborts with no done.
    launch(27, 45, 9, 1'b0);
    repeat (7) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_lcm",  longint'(lcm), 0);
    chk("abort_err",  longint'(err), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    run(17, 103, 1);

    // Start held high: a new run at every IDLE entry.
    begin
      exp_t   e;
      longint l;
      bit     er;
      int     lat;
      int     bc;
      int     e0;
      model(27, 45, 9, l, er, lat, bc);
      in1 = 8'd27; in2 = 8'd45; hcf = 8'd9; start = 1'b1;
      e0 = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        e.lcm = l; e.err = er; e.due = e0 + lat + k * (2 * N + 2); e.bcyc = bc;
        sb.push_back(e);
      end
      for (int k = 0; k < 4; k++) wait_done();
      start = 1'b0;
    end
    repeat (2) @(posedge clk); #1;

    // Random operands with a matching or perturbed HCF.
    for (int i = 0; i < 12; i++) begin
      int a = int'($urandom_range(1, 255));
      int b = int'($urandom_range(1, 255));
      int h = gcd(a, b);
      if (i % 3 == 2) h = int'($urandom_range(0, 255));
      run(a, b, h);
    end

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
